keccak_squeeze_unit: RTL

//  Squeeze-side AXI4-Stream source for the Keccak datapath. Captures the rate portion of the

---
 rtl/keccak_squeeze_unit_pkg.sv | 28 ++
 rtl/keccak_squeeze_unit_if.sv | 32 +++
 rtl/keccak_squeeze_unit_keep_gen.sv | 16 +
 rtl/keccak_squeeze_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/keccak_squeeze_unit_pkg.sv
// Shared Keccak datapath types and sizes used by the squeeze-side AXI4-Stream source.
package keccak_pkg;

    localparam int unsigned DWIDTH         = 64;
    localparam int unsigned KEEP_WIDTH     = DWIDTH / 8;
    localparam int unsigned MAX_RATE_BYTES = 168;
    localparam int unsigned LEN_WIDTH      = 16;
    localparam int unsigned RATE_WIDTH     = 8;
    localparam int unsigned STATE_WIDTH    = 1600;
    localparam int unsigned BUF_WIDTH      = MAX_RATE_BYTES * 8;
    localparam int unsigned CNT_WIDTH      = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [1:0] {
        SQ_IDLE       = 2'd0,
        SQ_WAIT_STATE = 2'd1,
        SQ_EMIT       = 2'd2,
        SQ_DONE       = 2'd3
    } squeeze_state_t;

    // Bytes carried by the next beat: a full beat unless fewer bytes remain.
    function automatic logic [CNT_WIDTH-1:0] beat_bytes(input logic [LEN_WIDTH-1:0] remaining);
        if (remaining >= LEN_WIDTH'(KEEP_WIDTH)) begin
            return CNT_WIDTH'(KEEP_WIDTH);
        end
        return remaining[CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/keccak_squeeze_unit_if.sv
// Control, state-capture and AXI4-Stream signals between the squeeze unit and its neighbours.
interface keccak_squeeze_unit_if;
    import keccak_pkg::*;

    logic                   start_i;
    logic [RATE_WIDTH-1:0]  rate_bytes_i;
    logic [LEN_WIDTH-1:0]   out_len_i;
    logic [STATE_WIDTH-1:0] state_i;
    logic                   state_valid_i;
    logic                   state_ready_o;
    logic                   perm_req_o;
    logic [DWIDTH-1:0]      t_data_o;
    logic [KEEP_WIDTH-1:0]  t_keep_o;
    logic                   t_valid_o;
    logic                   t_last_o;
    logic                   t_ready_i;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        output start_i, rate_bytes_i, out_len_i, state_i, state_valid_i, t_ready_i,
        input  state_ready_o, perm_req_o, t_data_o, t_keep_o, t_valid_o, t_last_o,
               busy_o, done_o
    );

    modport slave (
        input  start_i, rate_bytes_i, out_len_i, state_i, state_valid_i, t_ready_i,
        output state_ready_o, perm_req_o, t_data_o, t_keep_o, t_valid_o, t_last_o,
               busy_o, done_o
    );

endinterface

// File: rtl/keccak_squeeze_unit_keep_gen.sv
// Byte count to contiguous low-order byte-enable mask; shared by absorb and squeeze paths.
module keccak_keep_gen
    import keccak_pkg::*;
(
    input  logic [CNT_WIDTH-1:0]  count,
    output logic [KEEP_WIDTH-1:0] keep_c
);

    always_comb begin
        keep_c = '0;
        for (int k = 0; k < int'(KEEP_WIDTH); k++) begin
            keep_c[k] = (CNT_WIDTH'(k) < count);
        end
    end

endmodule

// File: rtl/keccak_squeeze_unit.sv
// Squeeze-side AXI4-Stream source: captures the rate part of the permuted state and
// serializes it into beats, requesting further permutations until out_len bytes are sent.
module keccak_squeeze_unit
    import keccak_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    keccak_squeeze_unit_if.slave  bus
);

    squeeze_state_t state_q;
    squeeze_state_t state_d;

    logic [BUF_WIDTH-1:0]  buf_q;
    logic [BUF_WIDTH-1:0]  cap_c;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [RATE_WIDTH-1:0] rate_q;
    logic [RATE_WIDTH-1:0] blk_q;

    logic [CNT_WIDTH-1:0]  n_c;
    logic [KEEP_WIDTH-1:0] keep_c;
    logic [LEN_WIDTH-1:0]  rem_after_c;
    logic [RATE_WIDTH-1:0] blk_after_c;
    logic                  cap_hs_c;
    logic                  beat_hs_c;
    logic                  unused_state_hi_c;

    logic                  state_ready_c;
    logic                  perm_req_c;
    logic [DWIDTH-1:0]     t_data_c;
    logic [KEEP_WIDTH-1:0] t_keep_c;
    logic                  t_valid_c;
    logic                  t_last_c;
    logic                  busy_c;
    logic                  done_c;

    // Lanes beyond the largest rate are capacity and never leave the unit.
    assign unused_state_hi_c = ^bus.state_i[STATE_WIDTH-1:BUF_WIDTH];

    assign n_c         = beat_bytes(rem_q);
    assign rem_after_c = rem_q - LEN_WIDTH'(n_c);
    assign blk_after_c = blk_q - RATE_WIDTH'(n_c);
    assign cap_hs_c    = (state_q == SQ_WAIT_STATE) && bus.state_valid_i;
    assign beat_hs_c   = (state_q == SQ_EMIT) && bus.t_ready_i;

    keccak_keep_gen u_keep_gen (
        .count  (n_c),
        .keep_c (keep_c)
    );

    // Only the low rate bytes are captured; the rest of the buffer is cleared.
    always_comb begin
        cap_c = '0;
        for (int b = 0; b < int'(MAX_RATE_BYTES); b++) begin
            if (b < int'(rate_q)) begin
                cap_c[b*8 +: 8] = bus.state_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SQ_IDLE: begin
                if (bus.start_i) begin
                    state_d = (bus.out_len_i == '0) ? SQ_DONE : SQ_WAIT_STATE;
                end
            end
            SQ_WAIT_STATE: begin
                if (cap_hs_c) begin
                    state_d = SQ_EMIT;
                end
            end
            SQ_EMIT: begin
                if (beat_hs_c) begin
                    if (rem_after_c == '0) begin
                        state_d = SQ_DONE;
                    end else if (blk_after_c == '0) begin
                        state_d = SQ_WAIT_STATE;
                    end
                end
            end
            SQ_DONE: state_d = SQ_IDLE;
            default: state_d = SQ_IDLE;
        endcase
    end

    // Beat payload is decoded straight from the buffer so it stays stable while stalled.
    always_comb begin
        state_ready_c = 1'b0;
        perm_req_c    = 1'b0;
        t_data_c      = '0;
        t_keep_c      = '0;
        t_valid_c     = 1'b0;
        t_last_c      = 1'b0;
        busy_c        = (state_q != SQ_IDLE);
        done_c        = 1'b0;
        case (state_q)
            SQ_WAIT_STATE: begin
                state_ready_c = 1'b1;
                perm_req_c    = cap_hs_c && (rem_q > LEN_WIDTH'(rate_q));
            end
            SQ_EMIT: begin
                t_valid_c = 1'b1;
                t_keep_c  = keep_c;
                t_last_c  = (rem_q <= LEN_WIDTH'(KEEP_WIDTH));
                for (int k = 0; k < int'(KEEP_WIDTH); k++) begin
                    if (keep_c[k]) begin
                        t_data_c[k*8 +: 8] = buf_q[k*8 +: 8];
                    end
                end
            end
            SQ_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            rem_q  <= '0;
            rate_q <= '0;
            blk_q  <= '0;
        end else begin
            if ((state_q == SQ_IDLE) && bus.start_i) begin
                rate_q <= bus.rate_bytes_i;
                rem_q  <= bus.out_len_i;
            end
            if (cap_hs_c) begin
                buf_q <= cap_c;
                blk_q <= rate_q;
            end
            if (beat_hs_c) begin
                buf_q <= buf_q >> DWIDTH;
                rem_q <= rem_after_c;
                blk_q <= blk_after_c;
            end
        end
    end

    assign bus.state_ready_o = state_ready_c;
    assign bus.perm_req_o    = perm_req_c;
    assign bus.t_data_o      = t_data_c;
    assign bus.t_keep_o      = t_keep_c;
    assign bus.t_valid_o     = t_valid_c;
    assign bus.t_last_o      = t_last_c;
    assign bus.busy_o        = busy_c;
    assign bus.done_o        = done_c;

endmodule
